// File: rtl/chip8_audio_pkg.sv
// rtl/chip8_audio_pkg.sv - shared types for the CHIP-8 audio path
package chip8_audio_pkg;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} beep_state_t;
endpackage

// File: rtl/chip8_beep_env.sv
// rtl/chip8_beep_env.sv - attack/sustain/release FSM and envelope register for the beep tone
module chip8_beep_env
  import chip8_audio_pkg::*;
#(
  parameter int unsigned ENV_SHIFT = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_req,
  input  logic               sound_on,
  output logic [ENV_SHIFT:0] env,
  output beep_state_t        state
);

  localparam logic [ENV_SHIFT:0] ENV_MAX = {1'b1, {ENV_SHIFT{1'b0}}};
  localparam logic [ENV_SHIFT:0] ENV_ONE = {{ENV_SHIFT{1'b0}}, 1'b1};

  logic [ENV_SHIFT:0] env_inc;
  logic [ENV_SHIFT:0] env_dec;

  // Saturating steps: env never wraps past 0 or ENV_MAX.
  always_comb begin
    env_inc = (env == ENV_MAX) ? env : env + ENV_ONE;
    env_dec = (env == '0) ? env : env - ENV_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      env   <= '0;
    end else if (sample_req) begin
      case (state)
        IDLE: begin
          if (sound_on) begin
            state <= ATTACK;
            env   <= ENV_ONE;
          end else begin
            env <= '0;
          end
        end
        ATTACK: begin
          if (!sound_on) begin
            state <= RELEASE;
            env   <= env_dec;
          end else begin
            env <= env_inc;
            if (env_inc == ENV_MAX) state <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (!sound_on) begin
            state <= RELEASE;
            env   <= ENV_MAX - ENV_ONE;
          end else begin
            env <= ENV_MAX;
          end
        end
        RELEASE: begin
          if (sound_on) begin
            state <= ATTACK;
            env   <= env_inc;
          end else begin
            env <= env_dec;
            if (env_dec == '0) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          env   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/chip8_beep_gen.sv
// rtl/chip8_beep_gen.sv - CHIP-8 buzzer PCM generator; CHIP8_BEEP_TRIANGLE_EN selects a triangle waveform
module chip8_beep_gen
  import chip8_audio_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 50,
  parameter logic [15:0] AMPLITUDE   = 16'h2000,
  parameter int unsigned ENV_SHIFT   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_req,
  input  logic       sound_on,
  input  logic [1:0] volume,
  output sample_t    audio_output,
  output logic       busy
);

  logic [ENV_SHIFT:0] env;
  beep_state_t        state;
  logic               req_d;
  logic               phase;
  logic               phase_n;
  logic [15:0]        half_cnt;
  logic [15:0]        half_cnt_n;
  sample_t            sample_n;

  chip8_beep_env #(.ENV_SHIFT(ENV_SHIFT)) u_env (
    .clk        (clk),
    .reset      (reset),
    .sample_req (sample_req),
    .sound_on   (sound_on),
    .env        (env),
    .state      (state)
  );

  // Runs one cycle behind sample_req, so state/env here are already post-update.
  always_comb begin
    half_cnt_n = half_cnt;
    phase_n    = phase;
    if (state == IDLE) begin
      half_cnt_n = '0;
      phase_n    = 1'b1;
    end else if (half_cnt == 16'(HALF_PERIOD - 1)) begin
      half_cnt_n = '0;
      phase_n    = ~phase;
    end else begin
      half_cnt_n = half_cnt + 16'd1;
    end
  end

`ifdef CHIP8_BEEP_TRIANGLE_EN
  localparam int               STEP    = 2 * int'(AMPLITUDE) / int'(HALF_PERIOD);
  localparam logic signed [17:0] AMP_S = 18'(AMPLITUDE);
  localparam int               TPROD_W = 18 + ENV_SHIFT + 2;

  logic signed [17:0]        ramp;
  logic signed [17:0]        ramp_n;
  logic signed [17:0]        ramp_sum;
  logic signed [TPROD_W-1:0] tprod;
  sample_t                   tmag;

  always_comb begin
    ramp_sum = phase_n ? ramp + 18'(STEP) : ramp - 18'(STEP);
    if (state == IDLE)          ramp_n = -AMP_S;
    else if (ramp_sum > AMP_S)  ramp_n = AMP_S;
    else if (ramp_sum < -AMP_S) ramp_n = -AMP_S;
    else                        ramp_n = ramp_sum;
    tprod    = TPROD_W'(ramp_n) * TPROD_W'($signed({1'b0, env}));
    tmag     = sample_t'(tprod >>> ENV_SHIFT);
    sample_n = tmag >>> (2'd3 - volume);
  end

  always_ff @(posedge clk) begin
    if (reset)      ramp <= -AMP_S;
    else if (req_d) ramp <= ramp_n;
  end
`else
  localparam int PROD_W = 16 + ENV_SHIFT + 1;

  logic [PROD_W-1:0] prod;
  logic [15:0]       mag;
  logic [15:0]       mag_v;

  always_comb begin
    prod     = PROD_W'(AMPLITUDE) * PROD_W'(env);
    mag      = 16'(prod >> ENV_SHIFT);
    mag_v    = mag >> (2'd3 - volume);
    sample_n = phase_n ? sample_t'(mag_v) : -sample_t'(mag_v);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      req_d        <= 1'b0;
      phase        <= 1'b1;
      half_cnt     <= '0;
      audio_output <= '0;
      busy         <= 1'b0;
    end else begin
      req_d <= sample_req;
      if (req_d) begin
        phase        <= phase_n;
        half_cnt     <= half_cnt_n;
        audio_output <= (state == IDLE) ? '0 : sample_n;
        busy         <= (state != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_chip8_beep_gen.sv
// tb/tb_chip8_beep_gen.sv - self-checking bench for chip8_beep_gen (square-wave build)
module tb_chip8_beep_gen;
  import chip8_audio_pkg::*;

  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_req = 1'b0;
  logic        sound_on = 1'b0;
  logic [1:0]  volume = 2'd3;
  logic [15:0] audio_output;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: envelope level, whether a tone is active, and the tone position.
  int m_env;
  bit m_active;
  bit m_releasing;
  bit m_phase;
  int m_cnt;

  typedef struct {
    bit          s;
    logic [15:0] out;
    bit          bz;
  } vec_t;
  vec_t tbl[6];

  chip8_beep_gen #(.HALF_PERIOD(HP)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_req   (sample_req),
    .sound_on     (sound_on),
    .volume       (volume),
    .audio_output (audio_output),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_env = 0; m_active = 0; m_releasing = 0; m_phase = 1; m_cnt = 0;
  endtask

  task automatic model_step(input bit s);
    if (!m_active) begin
      if (s) begin m_active = 1; m_env = 1; m_releasing = 0; end
      else m_env = 0;
    end else if (s) begin
      m_env = (m_env < 64) ? m_env + 1 : 64;
      m_releasing = 0;
    end else begin
      m_env = (m_env > 0) ? m_env - 1 : 0;
      if (m_env == 0 && m_releasing) m_active = 0;
      m_releasing = 1;
    end
    if (m_active) begin
      m_cnt++;
      if (m_cnt == HP) begin m_cnt = 0; m_phase = !m_phase; end
    end else begin
      m_cnt = 0; m_phase = 1;
    end
  endtask

  function automatic logic [15:0] m_out(input logic [1:0] v);
    int mag;
    if (!m_active) return 16'h0000;
    mag = ((32'h2000 * m_env) >> 6) & 16'hFFFF;
    mag = mag >> (3 - v);
    return m_phase ? 16'(mag) : 16'(-mag);
  endfunction

  function automatic int abs16(input logic [15:0] x);
    return x[15] ? int'(16'(-x)) : int'(x);
  endfunction

  task automatic pulse(input bit s);
    @(negedge clk); sample_req = 1'b1; sound_on = s;
    @(negedge clk); sample_req = 1'b0;
    model_step(s);
    @(negedge clk);
  endtask

  task automatic req(input bit s, input string name);
    pulse(s);
    check({name, " out"}, audio_output, m_out(volume));
    check({name, " busy"}, busy, m_active);
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h0080, 1'b1};
    tbl[1] = '{1'b1, 16'h0100, 1'b1};
    tbl[2] = '{1'b1, 16'h0180, 1'b1};
    tbl[3] = '{1'b1, 16'hFE00, 1'b1};
    tbl[4] = '{1'b1, 16'hFD80, 1'b1};
    tbl[5] = '{1'b1, 16'hFD00, 1'b1};
    model_reset();

    // Reset hold, with sample_req toggling underneath.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); sample_req = i[0]; sound_on = 1'b1;
      @(negedge clk);
      check("reset out", audio_output, 16'h0000);
      check("reset busy", busy, 1'b0);
    end
    sample_req = 1'b0; sound_on = 1'b0;
    @(negedge clk); reset = 1'b0;
    check("reset state", dut.u_env.state, IDLE);

    // Attack ramp start and first phase flip.
    for (int i = 0; i < 6; i++) begin
      pulse(tbl[i].s);
      check($sformatf("attack[%0d] out", i), audio_output, tbl[i].out);
      check($sformatf("attack[%0d] busy", i), busy, tbl[i].bz);
    end
    for (int i = 6; i < 64; i++) req(1'b1, "attack");
    check("sustain env", dut.u_env.env, 64);
    check("sustain state", dut.u_env.state, SUSTAIN);
    for (int i = 0; i < 8; i++) begin
      req(1'b1, "sustain");
      check("sustain mag", abs16(audio_output), 16'h2000);
    end

    // Release down to 40, reverse, then release to idle.
    for (int i = 0; i < 24; i++) req(1'b0, "release");
    check("release env40", dut.u_env.env, 40);
    check("release mag40", abs16(audio_output), 40 * 16'h80);
    req(1'b1, "reverse");
    check("reverse mag41", abs16(audio_output), 41 * 16'h80);
    for (int i = 0; i < 60 && m_active; i++) req(1'b0, "release2");
    check("idle out", audio_output, 16'h0000);
    check("idle busy", busy, 1'b0);

    // Volume scaling in sustain.
    for (int i = 0; i < 64; i++) pulse(1'b1);
    volume = 2'd1;
    for (int i = 0; i < 4; i++) begin
      req(1'b1, "vol1");
      check("vol1 mag", abs16(audio_output), 16'h0800);
    end
    volume = 2'd0;
    for (int i = 0; i < 4; i++) begin
      req(1'b1, "vol0");
      check("vol0 mag", abs16(audio_output), 16'h0400);
    end
    volume = 2'd3;

    // Back-to-back requests from env=10 in attack.
    for (int i = 0; i < 70 && m_active; i++) pulse(1'b0);
    for (int i = 0; i < 10; i++) pulse(1'b1);
    check("b2b env10", dut.u_env.env, 10);
    @(negedge clk); sample_req = 1'b1; sound_on = 1'b1;
    repeat (4) @(negedge clk);
    sample_req = 1'b0;
    for (int i = 0; i < 4; i++) model_step(1'b1);
    @(negedge clk);
    check("b2b env14", dut.u_env.env, 14);
    check("b2b half_cnt", dut.half_cnt, m_cnt);
    check("b2b out", audio_output, m_out(volume));

    // Mid-tone reset and restart.
    for (int i = 0; i < 55; i++) pulse(1'b1);
    check("pre-reset state", dut.u_env.state, SUSTAIN);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("midreset out", audio_output, 16'h0000);
    check("midreset busy", busy, 1'b0);
    check("midreset state", dut.u_env.state, IDLE);
    reset = 1'b0;
    model_reset();
    pulse(1'b1);
    check("restart out", audio_output, 16'h0080);
    check("restart busy", busy, 1'b1);

    // Randomized requests against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) volume = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sound_on = ~sound_on;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      req(sound_on, "random");
      check("random env", dut.u_env.env, m_env);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
